// File: rtl/fetch_unit_bp_pkg.sv
// Core-wide shared definitions for the fetch stage and its branch predictor:
// reset/bubble defaults, 2-bit counter encodings, the predictor entry record
// and the saturating counter helpers.
package fetch_unit_bp_pkg;

    // Datapath width the predictor entry record is sized for
    localparam int unsigned CORE_XLEN = 32;

    // PC after reset and the bubble instruction (addi x0,x0,0)
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

    // 2-bit saturating counter states; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // One direct-mapped predictor entry. The tag is kept as the PC shifted
    // right past the index bits (zero-extended), so the whole field compares.
    typedef struct packed {
        logic                 valid;
        logic [CORE_XLEN-1:0] tag;
        logic [CORE_XLEN-1:0] target;
        ctr_e                 ctr;
    } bht_entry_t;

    // Saturating increment toward strongly-taken
    function automatic ctr_e ctr_inc(input ctr_e c);
        ctr_e r;
        case (c)
            CTR_SNT: r = CTR_WNT;
            CTR_WNT: r = CTR_WT;
            CTR_WT:  r = CTR_ST;
            CTR_ST:  r = CTR_ST;
            default: r = CTR_WNT;
        endcase
        return r;
    endfunction

    // Saturating decrement toward strongly-not-taken
    function automatic ctr_e ctr_dec(input ctr_e c);
        ctr_e r;
        case (c)
            CTR_SNT: r = CTR_SNT;
            CTR_WNT: r = CTR_SNT;
            CTR_WT:  r = CTR_WNT;
            CTR_ST:  r = CTR_WT;
            default: r = CTR_WNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_bp_if.sv
// Bundle of the fetch stage's hazard, instruction-memory, execute-feedback
// and IF/ID signals. master = fetch unit, slave = the surrounding pipeline.
interface fetch_unit_bp_if
    import fetch_unit_bp_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
);
    // hazard unit controls
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    // instruction memory
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    // execute-stage resolution / training
    logic            upd_valid_e;
    logic [XLEN-1:0] upd_pc_e;
    logic            upd_taken_e;
    logic [XLEN-1:0] upd_target_e;
    logic            mispredict_e;
    logic [XLEN-1:0] redirect_pc_e;
    // IF/ID pipeline register
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic            pred_taken_d;
    logic [XLEN-1:0] pred_target_d;

    modport master (
        input  stall_f, stall_d, flush_d, imem_rdata,
        input  upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
        input  mispredict_e, redirect_pc_e,
        output imem_addr, instr_d, pc_d, pc_plus4_d, pred_taken_d, pred_target_d
    );

    modport slave (
        output stall_f, stall_d, flush_d, imem_rdata,
        output upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
        output mispredict_e, redirect_pc_e,
        input  imem_addr, instr_d, pc_d, pc_plus4_d, pred_taken_d, pred_target_d
    );

endinterface

// File: rtl/fetch_unit_bp_branch_predictor.sv
// Direct-mapped branch predictor: tagged entries with a 2-bit counter and a
// target. Combinational lookup on the fetch PC, clocked update from execute.
// A same-cycle update is not bypassed to the lookup (read-before-write).
module fetch_unit_bp_branch_predictor
    import fetch_unit_bp_pkg::*;
#(
    parameter int unsigned XLEN        = CORE_XLEN,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_lkp_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);

    bht_entry_t r_table [BHT_ENTRIES];

    logic [IDX-1:0]       w_lkp_idx;
    logic [CORE_XLEN-1:0] w_lkp_tag;
    logic                 w_lkp_hit;
    logic [IDX-1:0]       w_upd_idx;
    logic [CORE_XLEN-1:0] w_upd_tag;
    logic                 w_upd_hit;

    // PC[1:0] never reaches index or tag; the tag is everything above the index
    assign w_lkp_idx = i_lkp_pc[IDX+1:2];
    assign w_lkp_tag = CORE_XLEN'(i_lkp_pc >> (IDX + 2));
    assign w_upd_idx = i_upd_pc[IDX+1:2];
    assign w_upd_tag = CORE_XLEN'(i_upd_pc >> (IDX + 2));

    // Lookup: hit needs a valid entry with a matching tag; taken is counter MSB
    always_comb begin
        w_lkp_hit     = r_table[w_lkp_idx].valid && (r_table[w_lkp_idx].tag == w_lkp_tag);
        o_pred_taken  = w_lkp_hit && r_table[w_lkp_idx].ctr[1];
        o_pred_target = XLEN'(r_table[w_lkp_idx].target);
    end

    // Update-side tag check against the entry execute is training
    always_comb begin
        w_upd_hit = r_table[w_upd_idx].valid && (r_table[w_upd_idx].tag == w_upd_tag);
    end

    // Table storage: reset clears all entries, execute trains or allocates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (i_upd_valid) begin
            if (w_upd_hit) begin
                if (i_upd_taken) begin
                    r_table[w_upd_idx].ctr    <= ctr_inc(r_table[w_upd_idx].ctr);
                    r_table[w_upd_idx].target <= CORE_XLEN'(i_upd_target);
                end else begin
                    r_table[w_upd_idx].ctr    <= ctr_dec(r_table[w_upd_idx].ctr);
                end
            end else if (i_upd_taken) begin
                // miss on a taken branch replaces whatever lived at this index
                r_table[w_upd_idx] <= '{valid:  1'b1,
                                        tag:    w_upd_tag,
                                        target: CORE_XLEN'(i_upd_target),
                                        ctr:    CTR_WT};
            end
        end
    end

endmodule

// File: rtl/fetch_unit_bp.sv
// Instruction-fetch stage: PC register, next-PC selection (execute redirect,
// stall, predicted target, sequential) and the IF/ID pipeline register.
module fetch_unit_bp
    import fetch_unit_bp_pkg::*;
#(
    parameter int unsigned     XLEN        = CORE_XLEN,
    parameter int unsigned     BHT_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter logic [31:0]     NOP_INSTR   = DEF_NOP_INSTR
) (
    input logic              clk,
    input logic              rst,
    fetch_unit_bp_if.master  bus
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_pred_taken;
    logic [XLEN-1:0] w_pred_target;
    logic [XLEN-1:0] w_pred_target_d;

    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_pred_taken_d;
    logic [XLEN-1:0] r_pred_target_d;

    fetch_unit_bp_branch_predictor #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bp (
        .clk           (clk),
        .rst           (rst),
        .i_lkp_pc      (r_pcf),
        .o_pred_taken  (w_pred_taken),
        .o_pred_target (w_pred_target),
        .i_upd_valid   (bus.upd_valid_e),
        .i_upd_pc      (bus.upd_pc_e),
        .i_upd_taken   (bus.upd_taken_e),
        .i_upd_target  (bus.upd_target_e)
    );

    // wraps modulo 2^XLEN by construction
    assign w_pc_plus4 = r_pcf + PC_STEP;

    // Next-PC select: a mispredict redirect beats stall, which beats prediction
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (bus.mispredict_e) begin
            w_pc_next = bus.redirect_pc_e;
        end else if (bus.stall_f) begin
            w_pc_next = r_pcf;
        end else if (w_pred_taken) begin
            w_pc_next = w_pred_target;
        end else begin
            w_pc_next = w_pc_plus4;
        end
    end

    // Target carried into decode is zero unless the branch was predicted taken
    always_comb begin
        w_pred_target_d = '0;
        if (w_pred_taken) begin
            w_pred_target_d = w_pred_target;
        end else begin
            w_pred_target_d = '0;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcf <= RESET_PC;
        end else begin
            r_pcf <= w_pc_next;
        end
    end

    // IF/ID register: flush loads a bubble and wins over stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d       <= NOP_INSTR;
            r_pc_d          <= '0;
            r_pc_plus4_d    <= '0;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (bus.flush_d) begin
            r_instr_d       <= NOP_INSTR;
            r_pc_d          <= '0;
            r_pc_plus4_d    <= '0;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (!bus.stall_d) begin
            r_instr_d       <= bus.imem_rdata;
            r_pc_d          <= r_pcf;
            r_pc_plus4_d    <= w_pc_plus4;
            r_pred_taken_d  <= w_pred_taken;
            r_pred_target_d <= w_pred_target_d;
        end
    end

    assign bus.imem_addr     = r_pcf;
    assign bus.instr_d       = r_instr_d;
    assign bus.pc_d          = r_pc_d;
    assign bus.pc_plus4_d    = r_pc_plus4_d;
    assign bus.pred_taken_d  = r_pred_taken_d;
    assign bus.pred_target_d = r_pred_target_d;

endmodule

// File: tb/tb_fetch_unit_bp.sv
// Directed bench for fetch_unit_bp: expected IF/ID contents are queued when a
// cycle's stimulus is applied and compared after the clock edge.
module tb_fetch_unit_bp;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pt;
        logic [31:0] tgt;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: 32'h0000_0013, pc: 32'h0, pc4: 32'h0,
                                 pt: 1'b0, tgt: 32'h0};

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ifid_t       sb[$];
    ifid_t       last_ifid;
    logic [31:0] exp_pcf;

    fetch_unit_bp_if #(.XLEN(32)) bus ();

    fetch_unit_bp #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .RESET_PC    (32'h0000_0000),
        .NOP_INSTR   (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // instruction memory contents: a distinct word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        bus.stall_f       = 1'b0;
        bus.stall_d       = 1'b0;
        bus.flush_d       = 1'b0;
        bus.upd_valid_e   = 1'b0;
        bus.upd_pc_e      = 32'h0;
        bus.upd_taken_e   = 1'b0;
        bus.upd_target_e  = 32'h0;
        bus.mispredict_e  = 1'b0;
        bus.redirect_pc_e = 32'h0;
    endtask

    // One clock: queue the expected IF/ID value, clock, then check.
    // exp_pt/exp_tgt: the prediction expected for the current fetch PC.
    task automatic step(input string name, input logic exp_pt,
                        input logic [31:0] exp_tgt, input logic [31:0] exp_next);
        ifid_t e;
        ifid_t got;
        if (bus.flush_d) begin
            e = BUBBLE;
        end else if (bus.stall_d) begin
            e = last_ifid;
        end else begin
            e = '{instr: mem_word(exp_pcf), pc: exp_pcf, pc4: exp_pcf + 32'd4,
                  pt: exp_pt, tgt: (exp_pt ? exp_tgt : 32'h0)};
        end
        sb.push_back(e);
        last_ifid = e;
        @(posedge clk);
        #1;
        chk($sformatf("%s.imem_addr", name), bus.imem_addr, exp_next);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s.scoreboard: observed empty queue expected one entry", name);
        end else begin
            got = sb.pop_front();
            chk($sformatf("%s.instr_d", name),       bus.instr_d,               got.instr);
            chk($sformatf("%s.pc_d", name),          bus.pc_d,                  got.pc);
            chk($sformatf("%s.pc_plus4_d", name),    bus.pc_plus4_d,            got.pc4);
            chk($sformatf("%s.pred_taken_d", name),  {31'h0, bus.pred_taken_d}, {31'h0, got.pt});
            chk($sformatf("%s.pred_target_d", name), bus.pred_target_d,         got.tgt);
        end
        exp_pcf = exp_next;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk($sformatf("%s.imem_addr", name),     bus.imem_addr,             32'h0000_0000);
        chk($sformatf("%s.instr_d", name),       bus.instr_d,               32'h0000_0013);
        chk($sformatf("%s.pc_d", name),          bus.pc_d,                  32'h0);
        chk($sformatf("%s.pc_plus4_d", name),    bus.pc_plus4_d,            32'h0);
        chk($sformatf("%s.pred_taken_d", name),  {31'h0, bus.pred_taken_d}, 32'h0);
        chk($sformatf("%s.pred_target_d", name), bus.pred_target_d,         32'h0);
    endtask

    logic sat_pt [4];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_pcf   = 32'h0;
        last_ifid = BUBBLE;
        sat_pt[0] = 1'b1;   // 11 -> 10
        sat_pt[1] = 1'b0;   // 10 -> 01
        sat_pt[2] = 1'b0;   // 01 -> 00
        sat_pt[3] = 1'b0;   // 00 stays 00
        rst = 1'b1;
        idle();
        #2;
        chk_reset_outputs("reset");
        #10;
        rst = 1'b0;

        // sequential fetch, no prediction
        for (int i = 0; i < 4; i++) begin
            step("seq", 1'b0, 32'h0, exp_pcf + 32'd4);
        end

        // train 0x40 -> 0x100 twice (allocate at 10, then 11)
        bus.upd_valid_e  = 1'b1;
        bus.upd_pc_e     = 32'h0000_0040;
        bus.upd_taken_e  = 1'b1;
        bus.upd_target_e = 32'h0000_0100;
        step("train0", 1'b0, 32'h0, exp_pcf + 32'd4);
        step("train1", 1'b0, 32'h0, exp_pcf + 32'd4);
        idle();

        // redirect together with stall_f: redirect wins
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'h0000_003C;
        bus.stall_f       = 1'b1;
        step("redir_over_stall", 1'b0, 32'h0, 32'h0000_003C);
        idle();
        step("pre_branch", 1'b0, 32'h0, 32'h0000_0040);
        step("branch_hit", 1'b1, 32'h0000_0100, 32'h0000_0100);
        step("at_target",  1'b0, 32'h0, 32'h0000_0104);

        // mispredict to 0x44 with stall_f, plus flush_d and stall_d together
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'h0000_0044;
        bus.stall_f       = 1'b1;
        bus.flush_d       = 1'b1;
        bus.stall_d       = 1'b1;
        step("flush_over_stall", 1'b0, 32'h0, 32'h0000_0044);
        idle();
        step("after_flush", 1'b0, 32'h0, 32'h0000_0048);

        // stall_f holds PC while IF/ID keeps loading, then stall_d holds IF/ID
        bus.stall_f = 1'b1;
        step("stall_f", 1'b0, 32'h0, 32'h0000_0048);
        bus.stall_d = 1'b1;
        step("stall_fd", 1'b0, 32'h0, 32'h0000_0048);
        idle();

        // 0x140 shares the index of 0x40 with a different tag: no prediction
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'h0000_0140;
        step("to_alias", 1'b0, 32'h0, 32'h0000_0140);
        idle();
        step("alias_miss", 1'b0, 32'h0, 32'h0000_0144);

        // PC+4 wraps around the top of the address space
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'hFFFF_FFFC;
        step("to_top", 1'b0, 32'h0, 32'hFFFF_FFFC);
        idle();
        step("wrap", 1'b0, 32'h0, 32'h0000_0000);

        // four not-taken updates on 0x40, each followed by a fetch of 0x40
        for (int k = 0; k < 4; k++) begin
            bus.upd_valid_e   = 1'b1;
            bus.upd_pc_e      = 32'h0000_0040;
            bus.upd_taken_e   = 1'b0;
            bus.mispredict_e  = 1'b1;
            bus.redirect_pc_e = 32'h0000_0040;
            step("sat_go", 1'b0, 32'h0, 32'h0000_0040);
            idle();
            step($sformatf("sat%0d", k), sat_pt[k], 32'h0000_0100,
                 sat_pt[k] ? 32'h0000_0100 : 32'h0000_0044);
        end

        // not-taken update to an empty index allocates nothing
        bus.upd_valid_e   = 1'b1;
        bus.upd_pc_e      = 32'h0000_0080;
        bus.upd_taken_e   = 1'b0;
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'h0000_0080;
        step("nt_empty", 1'b0, 32'h0, 32'h0000_0080);
        idle();
        step("nt_no_alloc", 1'b0, 32'h0, 32'h0000_0084);

        // allocate 0x80 -> 0x200 while fetching 0x80: lookup sees old contents
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'h0000_0080;
        step("to_80", 1'b0, 32'h0, 32'h0000_0080);
        idle();
        bus.upd_valid_e  = 1'b1;
        bus.upd_pc_e     = 32'h0000_0080;
        bus.upd_taken_e  = 1'b1;
        bus.upd_target_e = 32'h0000_0200;
        step("rd_before_wr", 1'b0, 32'h0, 32'h0000_0084);
        idle();
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'h0000_0080;
        step("back_80", 1'b0, 32'h0, 32'h0000_0080);
        idle();
        step("alloc_hit", 1'b1, 32'h0000_0200, 32'h0000_0200);
        step("at_200",    1'b0, 32'h0, 32'h0000_0204);

        // asynchronous reset mid-stream with a trained table
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        sb.delete();
        exp_pcf   = 32'h0;
        last_ifid = BUBBLE;
        #2;
        rst = 1'b0;
        bus.mispredict_e  = 1'b1;
        bus.redirect_pc_e = 32'h0000_0080;
        step("post_rst_go", 1'b0, 32'h0, 32'h0000_0080);
        idle();
        step("post_rst_forgot", 1'b0, 32'h0, 32'h0000_0084);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
